// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner: active-low segment
// patterns in {g,f,e,d,c,b,a} order, anode enables and slot names.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  // Anode enables are active-low; AN_SLOT[i] selects display position i
  // (position 0 is the rightmost, ones digit).
  localparam logic [3:0]       AN_OFF  = 4'b1111;
  localparam logic [3:0][3:0]  AN_SLOT = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  // Scan slot, taken from the top two bits of the refresh counter.
  typedef enum logic [1:0] {
    SLOT_ONES      = 2'd0,
    SLOT_TENS      = 2'd1,
    SLOT_HUNDREDS  = 2'd2,
    SLOT_THOUSANDS = 2'd3
  } slot_e;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Values 10..15 are not BCD and show a dash so bad data is visible.
module bcd_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] pattern
);

  // Table lookup; anything outside 0..9 falls through to the dash.
  always_comb begin
    pattern = SEG_DASH;
    case (digit)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for a 4-digit common-anode display. Digits are
// latched on load and scanned at clk / 2^(CNT_W-2) per digit. Outputs are
// registered, so what appears at edge n+1 is the counter/latch state at n.
// CNT_W must be at least 3 so the slot index has bits of its own.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int CNT_W         = 18,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] thousands,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  logic [CNT_W-1:0] cnt_reg;
  logic [3:0]       digit_reg [4];
  logic [3:0][3:0]  digit_in;
  logic [3:0]       zero_flag;
  logic [3:0]       blank_vec;
  slot_e            slot;
  logic [3:0]       cur_digit;
  logic [6:0]       cur_pattern;
  logic [3:0]       an_reg, an_next;
  logic [6:0]       seg_reg, seg_next;

  assign digit_in = {thousands, hundreds, tens, ones};
  assign slot     = slot_e'(cnt_reg[CNT_W-1 -: 2]);

  // Free-running refresh counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst) cnt_reg <= '0;
    else      cnt_reg <= cnt_reg + CNT_W'(1);
  end

  // Digit latch: only a load strobe changes the held digits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) digit_reg[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < 4; i++) digit_reg[i] <= digit_in[i];
    end
  end

  // A position is a leading zero when it and every position to its left
  // hold exactly zero; non-BCD codes count as non-zero. Ones never blanks.
  assign blank_vec[0] = 1'b0;
  for (genvar gi = 0; gi < 4; gi++) begin : g_zero
    assign zero_flag[gi] = (digit_reg[gi] == 4'd0);
  end
  for (genvar gi = 1; gi < 4; gi++) begin : g_blank
    assign blank_vec[gi] = BLANK_LEADING && (&zero_flag[3:gi]);
  end

  // Single decoder shared by all positions, fed after the slot mux.
  assign cur_digit = digit_reg[slot];

  bcd_to_seg u_dec (
    .digit   (cur_digit),
    .pattern (cur_pattern)
  );

  // Select anode and pattern for the current slot, or darken it if blanked.
  always_comb begin
    an_next  = AN_OFF;
    seg_next = SEG_OFF;
    if (!blank_vec[slot]) begin
      an_next  = AN_SLOT[slot];
      seg_next = cur_pattern;
    end
  end

  // Output registers keep the board pins glitch-free.
  always_ff @(posedge clk) begin
    if (!rst) begin
      an_reg  <= AN_OFF;
      seg_reg <= SEG_OFF;
    end else begin
      an_reg  <= an_next;
      seg_reg <= seg_next;
    end
  end

  assign an  = an_reg;
  assign seg = seg_reg;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with CNT_W=4 (4 cycles per slot,
// 16-cycle frame). Two instances share stimulus: one with leading-zero
// blanking, one without. Outputs are sampled on the falling edge.
module tb_seven_seg_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [3:0] thousands = '0, hundreds = '0, tens = '0, ones = '0;
  logic [3:0] an_b, an_nb;
  logic [6:0] seg_b, seg_nb;
  logic       dp_b, dp_nb;

  int n_checks = 0;
  int n_pass   = 0;
  int cnt_m    = 0;   // expected refresh counter value sampled by the next rising edge

  localparam logic [3:0] OFF_AN  = 4'b1111;
  localparam logic [6:0] OFF_SEG = 7'b1111111;

  always #5 clk = ~clk;

  seven_seg_scanner #(.CNT_W(4), .BLANK_LEADING(1'b1)) dut_b (
    .clk(clk), .rst(rst), .load(load),
    .thousands(thousands), .hundreds(hundreds), .tens(tens), .ones(ones),
    .an(an_b), .seg(seg_b), .dp(dp_b)
  );

  seven_seg_scanner #(.CNT_W(4), .BLANK_LEADING(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .load(load),
    .thousands(thousands), .hundreds(hundreds), .tens(tens), .ones(ones),
    .an(an_nb), .seg(seg_nb), .dp(dp_nb)
  );

  always @(posedge clk) begin
    if (!rst) cnt_m <= 0;
    else      cnt_m <= (cnt_m + 1) % 16;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  task automatic load_digits(input logic [3:0] t, input logic [3:0] h,
                             input logic [3:0] te, input logic [3:0] o);
    thousands = t; hundreds = h; tens = te; ones = o;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    $display("load %h%h%h%h", t, h, te, o);
  endtask

  // Wait until the next rising edge samples counter 0 (start of slot 0).
  task automatic align();
    for (int k = 0; k < 20 && cnt_m != 0; k++) @(negedge clk);
    check("align", 32'(cnt_m == 0), 32'd1);
  endtask

  // Check one full frame; e_an/e_seg are indexed by slot (0 = ones).
  task automatic check_frame(input string tag, input bit sel,
                             input logic [3:0][3:0] e_an,
                             input logic [3:0][6:0] e_seg);
    align();
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        check($sformatf("%s s%0d c%0d an", tag, s, c), sel ? an_nb : an_b, e_an[s]);
        check($sformatf("%s s%0d c%0d seg", tag, s, c), sel ? seg_nb : seg_b, e_seg[s]);
      end
    end
    $display("frame %s checked", tag);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst an_b", an_b, OFF_AN);
    check("rst seg_b", seg_b, OFF_SEG);
    check("rst dp_b", dp_b, 1'b1);
    check("rst an_nb", an_nb, OFF_AN);
    check("rst seg_nb", seg_nb, OFF_SEG);
    rst = 1'b1;

    load_digits(4'd1, 4'd2, 4'd3, 4'd4);
    check_frame("1234_b", 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
    check_frame("1234_nb", 1'b1, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});

    load_digits(4'd0, 4'd0, 4'd0, 4'd7);
    check_frame("0007_b", 1'b0, {OFF_AN, OFF_AN, OFF_AN, 4'b1110},
                {OFF_SEG, OFF_SEG, OFF_SEG, 7'b1111000});

    load_digits(4'd0, 4'd0, 4'd0, 4'd0);
    check_frame("0000_b", 1'b0, {OFF_AN, OFF_AN, OFF_AN, 4'b1110},
                {OFF_SEG, OFF_SEG, OFF_SEG, 7'b1000000});
    check_frame("0000_nb", 1'b1, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000});

    load_digits(4'd0, 4'd0, 4'd5, 4'd0);
    check_frame("0050_nb", 1'b1, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b1000000, 7'b1000000, 7'b0010010, 7'b1000000});
    check_frame("0050_b", 1'b0, {OFF_AN, OFF_AN, 4'b1101, 4'b1110},
                {OFF_SEG, OFF_SEG, 7'b0010010, 7'b1000000});

    load_digits(4'd0, 4'd0, 4'd0, 4'hA);
    check_frame("000A_b", 1'b0, {OFF_AN, OFF_AN, OFF_AN, 4'b1110},
                {OFF_SEG, OFF_SEG, OFF_SEG, 7'b0111111});

    load_digits(4'd0, 4'd0, 4'hF, 4'd1);
    check_frame("00F1_b", 1'b0, {OFF_AN, OFF_AN, 4'b1101, 4'b1110},
                {OFF_SEG, OFF_SEG, 7'b0111111, 7'b1111001});

    // Mid-slot load during slot 0: ones 4 -> 9
    load_digits(4'd1, 4'd2, 4'd3, 4'd4);
    align();
    @(negedge clk);
    check("mid before seg", seg_b, 7'b0011001);
    ones = 4'd9;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("mid load-edge seg", seg_b, 7'b0011001);
    check("mid load-edge an", an_b, 4'b1110);
    @(negedge clk);
    check("mid after seg", seg_b, 7'b0010000);
    check("mid after an", an_b, 4'b1110);
    @(negedge clk);
    check("mid after2 seg", seg_b, 7'b0010000);
    $display("mid-slot load checked");

    // Reset mid-frame together with load: reset wins, latch clears
    @(negedge clk);
    thousands = 4'd8; hundreds = 4'd8; tens = 4'd8; ones = 4'd8;
    rst = 1'b0;
    load = 1'b1;
    @(negedge clk);
    check("mrst an_b", an_b, OFF_AN);
    check("mrst seg_b", seg_b, OFF_SEG);
    check("mrst dp_b", dp_b, 1'b1);
    check("mrst an_nb", an_nb, OFF_AN);
    rst = 1'b1;
    load = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("post-rst c%0d an_b", c), an_b, 4'b1110);
      check($sformatf("post-rst c%0d seg_b", c), seg_b, 7'b1000000);
      check($sformatf("post-rst c%0d an_nb", c), an_nb, 4'b1110);
    end
    @(negedge clk);
    check("post-rst slot1 an_b", an_b, OFF_AN);
    check("post-rst slot1 an_nb", an_nb, 4'b1101);
    check("post-rst slot1 seg_nb", seg_nb, 7'b1000000);
    $display("mid-frame reset checked");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
